// File: rtl/cr16_defs.sv
// Shared definitions for the cr16 datapath test controller: ALU opcodes,
// sequencer state encodings and register-file size.
package cr16_defs;

  localparam int unsigned NUM_REGS = 16;

  typedef enum logic [3:0] {
    OP_PASS = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NOT  = 4'h6,
    OP_SHL  = 4'h7,
    OP_SHR  = 4'h8
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_PRELOAD = 2'd1,
    S_COMPUTE = 2'd2,
    S_DONE    = 2'd3
  } seq_state_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [3:0] idx);
    return NUM_REGS'(1) << idx;
  endfunction

endpackage

// File: rtl/cr16_step_divider.sv
// Dwell counter for the Fibonacci sequencer: counts 0..STEP_CYCLES-1 while enabled
// and flags the last cycle of each dwell with a one-cycle tick.
module cr16_step_divider #(
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic I_CLK,
  input  logic I_NRESET,
  input  logic I_ENABLE,
  output logic O_TICK
);

  localparam int unsigned CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q;

  assign O_TICK = I_ENABLE && (cnt_q == CNT_LAST);

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      cnt_q <= '0;
    end else if (I_ENABLE) begin
      cnt_q <= O_TICK ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/cr16_fib_sequencer_fsm.sv
// Hard-coded program sequencer: preloads two seeds into r0/r1, then fills r2..rLAST_REG
// with a Fibonacci sequence via the datapath ALU. CR16_FIB_LOOP_EN makes the program repeat.
module cr16_fib_sequencer_fsm
  import cr16_defs::*;
#(
  parameter int unsigned STEP_CYCLES = 1,
  parameter logic [15:0] SEED0       = 16'd0,
  parameter logic [15:0] SEED1       = 16'd1,
  parameter int unsigned LAST_REG    = 15
) (
  input  logic        I_CLK,
  input  logic        I_NRESET,
  input  logic        I_ENABLE,
  output logic [3:0]  O_OPCODE,
  output logic [3:0]  O_READ_PORT_A_SEL,
  output logic [3:0]  O_READ_PORT_B_SEL,
  output logic [15:0] O_REG_ENABLE,
  output logic [15:0] O_PRELOAD_IMM,
  output logic        O_IMM_SEL,
  output logic [3:0]  O_STEP,
  output logic        O_DONE
);

  localparam logic [3:0] LAST_STEP = 4'(LAST_REG);

  seq_state_e  state_q;
  logic        active;
  logic        tick;
  logic        restart;
  logic [3:0]  nxt_step;
  logic [3:0]  nxt_opcode;
  logic [3:0]  nxt_a_sel;
  logic [3:0]  nxt_b_sel;
  logic        nxt_imm_sel;
  logic [15:0] nxt_imm;

  assign active = (state_q == S_PRELOAD) || (state_q == S_COMPUTE);

  // The divider only runs while a step is actually dwelling, so pausing freezes it too.
  cr16_step_divider #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_divider (
    .I_CLK   (I_CLK),
    .I_NRESET(I_NRESET),
    .I_ENABLE(I_ENABLE && active),
    .O_TICK  (tick)
  );

  // tick already includes I_ENABLE, so a pause drops the write strobe immediately.
  assign O_REG_ENABLE = tick ? reg_onehot(O_STEP) : '0;

  // Control word for the step that will be entered on the next advance.
  always_comb begin
    restart     = (state_q == S_IDLE) || (state_q == S_DONE);
    nxt_step    = restart ? 4'd0 : O_STEP + 4'd1;
    nxt_imm_sel = (nxt_step < 4'd2);
    nxt_imm     = '0;
    if (nxt_step == 4'd0) begin
      nxt_imm = SEED0;
    end else if (nxt_step == 4'd1) begin
      nxt_imm = SEED1;
    end
    nxt_opcode = nxt_imm_sel ? OP_PASS : OP_ADD;
    nxt_a_sel  = nxt_imm_sel ? 4'd0 : nxt_step - 4'd1;
    nxt_b_sel  = nxt_imm_sel ? 4'd0 : nxt_step - 4'd2;
  end

  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q           <= S_IDLE;
      O_STEP            <= '0;
      O_OPCODE          <= '0;
      O_READ_PORT_A_SEL <= '0;
      O_READ_PORT_B_SEL <= '0;
      O_PRELOAD_IMM     <= '0;
      O_IMM_SEL         <= 1'b0;
      O_DONE            <= 1'b0;
    end else if (I_ENABLE) begin
      unique case (state_q)
        S_IDLE: begin
          state_q           <= S_PRELOAD;
          O_STEP            <= nxt_step;
          O_OPCODE          <= nxt_opcode;
          O_READ_PORT_A_SEL <= nxt_a_sel;
          O_READ_PORT_B_SEL <= nxt_b_sel;
          O_PRELOAD_IMM     <= nxt_imm;
          O_IMM_SEL         <= nxt_imm_sel;
        end
        S_PRELOAD, S_COMPUTE: begin
          if (tick) begin
            if (O_STEP == LAST_STEP) begin
              state_q <= S_DONE;
              O_DONE  <= 1'b1;
            end else begin
              state_q           <= nxt_imm_sel ? S_PRELOAD : S_COMPUTE;
              O_STEP            <= nxt_step;
              O_OPCODE          <= nxt_opcode;
              O_READ_PORT_A_SEL <= nxt_a_sel;
              O_READ_PORT_B_SEL <= nxt_b_sel;
              O_PRELOAD_IMM     <= nxt_imm;
              O_IMM_SEL         <= nxt_imm_sel;
            end
          end
        end
        S_DONE: begin
`ifdef CR16_FIB_LOOP_EN
          state_q           <= S_PRELOAD;
          O_DONE            <= 1'b0;
          O_STEP            <= nxt_step;
          O_OPCODE          <= nxt_opcode;
          O_READ_PORT_A_SEL <= nxt_a_sel;
          O_READ_PORT_B_SEL <= nxt_b_sel;
          O_PRELOAD_IMM     <= nxt_imm;
          O_IMM_SEL         <= nxt_imm_sel;
`else
          state_q <= S_DONE;
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cr16_fib_sequencer_fsm.sv
// Scoreboard bench for cr16_fib_sequencer_fsm: three instances (1-cycle step, 4-cycle step,
// wrapping seeds) feeding a behavioural register file checked against hand-computed sequences.
module tb_cr16_fib_sequencer_fsm;
  import cr16_defs::*;

  typedef struct packed {
    logic [15:0] en;
    logic        imm_sel;
    logic [15:0] imm;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] data;
  } wr_t;

  logic clk;
  logic        rst_n   [3];
  logic        en      [3];
  logic [3:0]  opc     [3];
  logic [3:0]  a_sel   [3];
  logic [3:0]  b_sel   [3];
  logic [15:0] reg_en  [3];
  logic [15:0] imm     [3];
  logic        imm_sel [3];
  logic [3:0]  step    [3];
  logic        done    [3];

  logic [15:0] rf [3][16];
  wr_t         exp_q [3][$];
  logic [15:0] fib_a [16];
  logic [15:0] fib_b [16];

  int checks   = 0;
  int failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  cr16_fib_sequencer_fsm #(
    .STEP_CYCLES(1), .SEED0(16'h0000), .SEED1(16'h0001), .LAST_REG(15)
  ) dut0 (
    .I_CLK(clk), .I_NRESET(rst_n[0]), .I_ENABLE(en[0]), .O_OPCODE(opc[0]),
    .O_READ_PORT_A_SEL(a_sel[0]), .O_READ_PORT_B_SEL(b_sel[0]), .O_REG_ENABLE(reg_en[0]),
    .O_PRELOAD_IMM(imm[0]), .O_IMM_SEL(imm_sel[0]), .O_STEP(step[0]), .O_DONE(done[0])
  );

  cr16_fib_sequencer_fsm #(
    .STEP_CYCLES(4), .SEED0(16'h0000), .SEED1(16'h0001), .LAST_REG(15)
  ) dut1 (
    .I_CLK(clk), .I_NRESET(rst_n[1]), .I_ENABLE(en[1]), .O_OPCODE(opc[1]),
    .O_READ_PORT_A_SEL(a_sel[1]), .O_READ_PORT_B_SEL(b_sel[1]), .O_REG_ENABLE(reg_en[1]),
    .O_PRELOAD_IMM(imm[1]), .O_IMM_SEL(imm_sel[1]), .O_STEP(step[1]), .O_DONE(done[1])
  );

  cr16_fib_sequencer_fsm #(
    .STEP_CYCLES(1), .SEED0(16'hFFFF), .SEED1(16'h0002), .LAST_REG(15)
  ) dut2 (
    .I_CLK(clk), .I_NRESET(rst_n[2]), .I_ENABLE(en[2]), .O_OPCODE(opc[2]),
    .O_READ_PORT_A_SEL(a_sel[2]), .O_READ_PORT_B_SEL(b_sel[2]), .O_REG_ENABLE(reg_en[2]),
    .O_PRELOAD_IMM(imm[2]), .O_IMM_SEL(imm_sel[2]), .O_STEP(step[2]), .O_DONE(done[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int i, input int k, input logic [15:0] data);
    wr_t e;
    e.en      = 16'(1) << k;
    e.imm_sel = (k < 2);
    e.imm     = (k < 2) ? data : 16'h0000;
    e.a       = (k >= 2) ? 4'(k - 1) : 4'd0;
    e.b       = (k >= 2) ? 4'(k - 2) : 4'd0;
    e.data    = data;
    exp_q[i].push_back(e);
  endtask

  task automatic chk_zero(input int i, input string tag);
    check($sformatf("%s%0d_step", tag, i), 32'(step[i]), 0);
    check($sformatf("%s%0d_opcode", tag, i), 32'(opc[i]), 0);
    check($sformatf("%s%0d_a_sel", tag, i), 32'(a_sel[i]), 0);
    check($sformatf("%s%0d_b_sel", tag, i), 32'(b_sel[i]), 0);
    check($sformatf("%s%0d_reg_en", tag, i), 32'(reg_en[i]), 0);
    check($sformatf("%s%0d_imm", tag, i), 32'(imm[i]), 0);
    check($sformatf("%s%0d_imm_sel", tag, i), 32'(imm_sel[i]), 0);
    check($sformatf("%s%0d_done", tag, i), 32'(done[i]), 0);
  endtask

  // Monitor: behavioural datapath plus scoreboard pop on every write strobe.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reg_en[i] != 16'h0000) begin
        if (exp_q[i].size() == 0) begin
          check($sformatf("dut%0d_unexpected_write", i), 32'(reg_en[i]), 0);
        end else begin
          wr_t e;
          logic [15:0] wdata;
          int idx;
          e = exp_q[i].pop_front();
          idx = 0;
          for (int b = 0; b < 16; b++) if (reg_en[i][b]) idx = b;
          check($sformatf("dut%0d_wr_en", i), 32'(reg_en[i]), 32'(e.en));
          check($sformatf("dut%0d_wr_imm_sel", i), 32'(imm_sel[i]), 32'(e.imm_sel));
          check($sformatf("dut%0d_wr_imm", i), 32'(imm[i]), 32'(e.imm));
          if (!e.imm_sel) begin
            check($sformatf("dut%0d_wr_opcode", i), 32'(opc[i]), 32'(OP_ADD));
            check($sformatf("dut%0d_wr_a_sel", i), 32'(a_sel[i]), 32'(e.a));
            check($sformatf("dut%0d_wr_b_sel", i), 32'(b_sel[i]), 32'(e.b));
          end
          wdata = imm_sel[i] ? imm[i] : rf[i][a_sel[i]] + rf[i][b_sel[i]];
          check($sformatf("dut%0d_wr_data_r%0d", i, idx), 32'(wdata), 32'(e.data));
          rf[i][idx] = wdata;
        end
      end
    end
  end

  initial begin
    int done_at;
    fib_a = '{16'd0, 16'd1, 16'd1, 16'd2, 16'd3, 16'd5, 16'd8, 16'd13,
              16'd21, 16'd34, 16'd55, 16'd89, 16'd144, 16'd233, 16'd377, 16'd610};
    fib_b = '{16'hFFFF, 16'd2, 16'd1, 16'd3, 16'd4, 16'd7, 16'd11, 16'd18,
              16'd29, 16'd47, 16'd76, 16'd123, 16'd199, 16'd322, 16'd521, 16'd843};
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0;
      en[i]    = 1'b0;
      for (int r = 0; r < 16; r++) rf[i][r] = 16'h0000;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) chk_zero(i, "reset_dut");
    for (int i = 0; i < 3; i++) rst_n[i] = 1'b1;
    @(negedge clk);
    chk_zero(0, "idle_dut");

    // 1-cycle steps: write strobe walks r0..r15, done follows the r15 write.
    for (int k = 0; k < 16; k++) push_wr(0, k, fib_a[k]);
`ifdef CR16_FIB_LOOP_EN
    push_wr(0, 0, fib_a[0]);
`endif
    en[0] = 1'b1;
    done_at = -1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (done[0] && done_at < 0) done_at = c;
      if (c < 16) check($sformatf("walk_c%0d", c), 32'(reg_en[0]), 32'(16'(1) << c));
      if (c == 16) check("done_c16_reg_en", 32'(reg_en[0]), 0);
`ifdef CR16_FIB_LOOP_EN
      if (c == 17) begin
        check("loop_done_pulse", 32'(done[0]), 0);
        check("loop_restart_reg_en", 32'(reg_en[0]), 32'h0001);
        #1 en[0] = 1'b0;
        break;
      end
`else
      if (c == 24) check("done_sticky", 32'(done[0]), 1);
`endif
    end
    en[0] = 1'b0;
    check("done_cycle", 32'(done_at), 16);
    check("fib_r2", 32'(rf[0][2]), 1);
    check("fib_r10", 32'(rf[0][10]), 55);
    check("fib_r15", 32'(rf[0][15]), 610);
    check("dut0_queue_empty", 32'(exp_q[0].size()), 0);

    // Wrapping seeds: 0xFFFF + 0x0002 must give 0x0001.
    for (int k = 0; k < 16; k++) push_wr(2, k, fib_b[k]);
    en[2] = 1'b1;
    done_at = -1;
    for (int c = 0; c < 30 && done_at < 0; c++) begin
      @(negedge clk);
      if (done[2]) done_at = c;
    end
    #1 en[2] = 1'b0;
    check("wrap_done_cycle", 32'(done_at), 16);
    @(negedge clk);
    check("wrap_r2", 32'(rf[2][2]), 32'h0001);
    check("wrap_r3", 32'(rf[2][3]), 3);
    check("wrap_r15", 32'(rf[2][15]), 843);
    check("dut2_queue_empty", 32'(exp_q[2].size()), 0);

    // 4-cycle steps: one-cycle strobe on the 4th cycle, stable selects throughout.
    for (int k = 0; k < 16; k++) push_wr(1, k, fib_a[k]);
    en[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        check($sformatf("s4_k%0d_j%0d_reg_en", k, j), 32'(reg_en[1]),
              (j == 3) ? 32'(16'(1) << k) : 32'h0);
        check($sformatf("s4_k%0d_j%0d_step", k, j), 32'(step[1]), 32'(k));
        if (k >= 2) begin
          check($sformatf("s4_k%0d_j%0d_a", k, j), 32'(a_sel[1]), 32'(k - 1));
          check($sformatf("s4_k%0d_j%0d_b", k, j), 32'(b_sel[1]), 32'(k - 2));
        end
      end
    end
    // Pause for 10 cycles in the middle of step 5.
    @(negedge clk);
    @(negedge clk);
    #1 en[1] = 1'b0;
    for (int p = 0; p < 10; p++) begin
      @(negedge clk);
      check($sformatf("pause%0d_reg_en", p), 32'(reg_en[1]), 0);
      check($sformatf("pause%0d_step", p), 32'(step[1]), 5);
      check($sformatf("pause%0d_a", p), 32'(a_sel[1]), 4);
      check($sformatf("pause%0d_b", p), 32'(b_sel[1]), 3);
      check($sformatf("pause%0d_opcode", p), 32'(opc[1]), 32'(OP_ADD));
      check($sformatf("pause%0d_done", p), 32'(done[1]), 0);
    end
    #1 en[1] = 1'b1;
    @(negedge clk);
    check("resume_a_reg_en", 32'(reg_en[1]), 0);
    @(negedge clk);
    check("resume_b_reg_en", 32'(reg_en[1]), 32'h0020);
    @(negedge clk);
    check("resume_c_step", 32'(step[1]), 6);
    check("resume_c_reg_en", 32'(reg_en[1]), 0);
    check("resume_r5", 32'(rf[1][5]), 5);
    repeat (5) @(negedge clk);
    check("pre_reset_step", 32'(step[1]), 7);
    // Asynchronous reset in mid-step 7, away from any clock edge.
    #2 rst_n[1] = 1'b0;
    #1 chk_zero(1, "async_reset_dut");
    exp_q[1].delete();
    push_wr(1, 0, fib_a[0]);
    @(negedge clk);
    rst_n[1] = 1'b1;
    @(negedge clk);
    check("restart_step", 32'(step[1]), 0);
    check("restart_imm_sel", 32'(imm_sel[1]), 1);
    check("restart_reg_en", 32'(reg_en[1]), 0);
    repeat (3) @(negedge clk);
    check("restart_pulse", 32'(reg_en[1]), 32'h0001);
    #1 en[1] = 1'b0;
    repeat (2) @(negedge clk);
    check("dut1_queue_empty", 32'(exp_q[1].size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
